// File: rtl/imgproc_msg_pkg.sv
// Shared definitions for the image-processor message reader: FSM states,
// slave register map, message ID, status fields and coordinate slices.
package imgproc_msg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_POLL_RD = 4'd1,
    ST_POLL_WT = 4'd2,
    ST_ID_RD   = 4'd3,
    ST_ID_WT   = 4'd4,
    ST_TL_RD   = 4'd5,
    ST_TL_WT   = 4'd6,
    ST_BR_RD   = 4'd7,
    ST_BR_WT   = 4'd8,
    ST_OUT     = 4'd9,
    ST_RESYNC  = 4'd10
  } state_t;

  localparam logic [2:0]  STATUS_ADDR = 3'd0;
  localparam logic [2:0]  MSG_ADDR    = 3'd1;
  localparam logic [2:0]  REG_BBCOL   = 3'd2;
  localparam logic [31:0] MSG_ID      = 32'h00524242;

  localparam int CNT_LSB   = 8;
  localparam int CNT_MSB   = 15;
  localparam int FLUSH_BIT = 4;
  localparam logic [31:0] FLUSH_WORD = 32'h1 << FLUSH_BIT;

  localparam int COORD_W = 11;
  localparam int X_LSB   = 16;
  localparam int X_MSB   = 26;
  localparam int Y_LSB   = 0;
  localparam int Y_MSB   = 10;

  localparam int MSG_WORDS = 3;

  function automatic logic [COORD_W-1:0] word_x(input logic [31:0] w);
    return w[X_MSB:X_LSB];
  endfunction

  function automatic logic [COORD_W-1:0] word_y(input logic [31:0] w);
    return w[Y_MSB:Y_LSB];
  endfunction

  function automatic logic [7:0] status_count(input logic [31:0] w);
    return w[CNT_MSB:CNT_LSB];
  endfunction

endpackage

// File: rtl/imgproc_msg_reader.sv
// Avalon-MM master that polls the image processor's message FIFO and emits decoded boxes.
// Optional macro IMGPROC_MSGRD_FLUSH_EN: on a bad ID word, flush the slave FIFO instead of popping word-by-word.
module imgproc_msg_reader #(
  parameter int unsigned POLL_INTERVAL = 1024,
  parameter logic [31:0] MSG_ID        = imgproc_msg_pkg::MSG_ID,
  parameter logic [2:0]  STATUS_ADDR   = imgproc_msg_pkg::STATUS_ADDR,
  parameter logic [2:0]  MSG_ADDR      = imgproc_msg_pkg::MSG_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic        box_valid,
  input  logic        box_ready,
  output logic [10:0] box_left,
  output logic [10:0] box_top,
  output logic [10:0] box_right,
  output logic [10:0] box_bottom,
  output logic        box_present,
  output logic [7:0]  sync_err_cnt,
  output logic [3:0]  dbg_state
);
  import imgproc_msg_pkg::*;

  localparam int TW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_INTERVAL - 1);

  // Handshake: box_* is offered while box_valid=1 and transfers on the clock
  // edge where box_valid & box_ready; box_* is held until that edge.

  state_t             r_state;
  state_t             w_next;
  logic [TW-1:0]      r_timer;
  logic [COORD_W-1:0] r_tl_x;
  logic [COORD_W-1:0] r_tl_y;
  logic [COORD_W-1:0] r_box_left;
  logic [COORD_W-1:0] r_box_top;
  logic [COORD_W-1:0] r_box_right;
  logic [COORD_W-1:0] r_box_bottom;
  logic [7:0]         r_sync_err;

  logic w_timer_done;
  logic w_have_msg;
  logic w_is_id;

  assign w_timer_done = (r_timer == '0);
  assign w_have_msg   = (status_count(m_readdata) >= 8'(MSG_WORDS));
  assign w_is_id      = (m_readdata == MSG_ID);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_timer_done && enable) w_next = ST_POLL_RD;
      ST_POLL_RD: w_next = ST_POLL_WT;
      // A message is only started while enabled; never pop an under-filled FIFO.
      ST_POLL_WT: w_next = (w_have_msg && enable) ? ST_ID_RD : ST_IDLE;
      ST_ID_RD:   w_next = ST_ID_WT;
      ST_ID_WT:   w_next = w_is_id ? ST_TL_RD : ST_RESYNC;
      ST_TL_RD:   w_next = ST_TL_WT;
      ST_TL_WT:   w_next = ST_BR_RD;
      ST_BR_RD:   w_next = ST_BR_WT;
      ST_BR_WT:   w_next = ST_OUT;
      ST_OUT:     if (box_ready) w_next = enable ? ST_POLL_RD : ST_IDLE;
      ST_RESYNC:  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    m_chipselect = 1'b0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_address    = 3'd0;
    m_writedata  = 32'd0;
    case (r_state)
      ST_POLL_RD: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
        m_address    = STATUS_ADDR;
      end
      ST_ID_RD, ST_TL_RD, ST_BR_RD: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
        m_address    = MSG_ADDR;
      end
`ifdef IMGPROC_MSGRD_FLUSH_EN
      ST_RESYNC: begin
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_address    = STATUS_ADDR;
        m_writedata  = FLUSH_WORD;
      end
`endif
      default: ;
    endcase
  end

  // Timer only runs in IDLE and is reloaded as IDLE is left, so every
  // return to IDLE waits a full interval before the next poll.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= TIMER_RELOAD;
    end else if (r_state == ST_IDLE) begin
      if (w_timer_done) begin
        if (enable) r_timer <= TIMER_RELOAD;
      end else begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tl_x       <= '0;
      r_tl_y       <= '0;
      r_box_left   <= '0;
      r_box_top    <= '0;
      r_box_right  <= '0;
      r_box_bottom <= '0;
    end else if (r_state == ST_TL_WT) begin
      r_tl_x <= word_x(m_readdata);
      r_tl_y <= word_y(m_readdata);
    end else if (r_state == ST_BR_WT) begin
      // Output regs load only on the edge into OUT so box_* never changes mid-offer.
      r_box_left   <= r_tl_x;
      r_box_top    <= r_tl_y;
      r_box_right  <= word_x(m_readdata);
      r_box_bottom <= word_y(m_readdata);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_err <= 8'd0;
    end else if (r_state == ST_RESYNC && r_sync_err != 8'hFF) begin
      r_sync_err <= r_sync_err + 8'd1;
    end
  end

  assign box_valid    = (r_state == ST_OUT);
  assign box_left     = r_box_left;
  assign box_top      = r_box_top;
  assign box_right    = r_box_right;
  assign box_bottom   = r_box_bottom;
  // Qualified by box_valid so the idle/reset value reads as "no detection".
  assign box_present  = box_valid && (r_box_left <= r_box_right) && (r_box_top <= r_box_bottom);
  assign sync_err_cnt = r_sync_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_imgproc_msg_reader.sv
// Directed bench for imgproc_msg_reader with a latency-1 MM slave FIFO model.
module tb_imgproc_msg_reader;
  import imgproc_msg_pkg::*;

  localparam int P = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        m_chipselect;
  logic        m_read;
  logic        m_write;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = 32'd0;
  logic        box_valid;
  logic        box_ready;
  logic [10:0] box_left;
  logic [10:0] box_top;
  logic [10:0] box_right;
  logic [10:0] box_bottom;
  logic        box_present;
  logic [7:0]  sync_err_cnt;
  logic [3:0]  dbg_state;

  always #5 clk = ~clk;

  imgproc_msg_reader #(.POLL_INTERVAL(P)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
    .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .box_valid(box_valid), .box_ready(box_ready),
    .box_left(box_left), .box_top(box_top), .box_right(box_right), .box_bottom(box_bottom),
    .box_present(box_present), .sync_err_cnt(sync_err_cnt), .dbg_state(dbg_state)
  );

  // Slave: FIFO written by the stimulus (wr_ptr), popped by the slave (rd_ptr).
  logic [31:0] fifo_mem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  logic [7:0]  fifo_cnt;
  assign fifo_cnt = wr_ptr - rd_ptr;

  always @(posedge clk) begin
    if (m_chipselect && m_read) begin
      if (m_address == STATUS_ADDR) m_readdata <= {16'h0, fifo_cnt, 8'h0};
      else if (m_address == MSG_ADDR) begin
        m_readdata <= (fifo_cnt == 8'd0) ? 32'hBAD0BAD0 : fifo_mem[rd_ptr];
        if (fifo_cnt != 8'd0) rd_ptr <= rd_ptr + 8'd1;
      end
    end
    if (m_chipselect && m_write && m_address == STATUS_ADDR && m_writedata[4]) rd_ptr <= wr_ptr;
  end

  // Bus monitor, sampled on the falling edge.
  int          cyc = 0;
  int          n_st = 0, n_msg = 0, n_wr = 0, n_box = 0, n_viol = 0, n_under = 0;
  int          st_prev = 0, st_last = 0, hs_st = 0, hs_msg = 0;
  logic [31:0] wr_data = 32'd0;
  logic [2:0]  wr_addr = 3'd7;
  logic [10:0] cap_l = 11'd0, cap_t = 11'd0, cap_r = 11'd0, cap_b = 11'd0;
  logic        cap_p = 1'b0;
  logic        prev_read = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_chipselect && m_read) begin
      if (m_address == STATUS_ADDR) begin
        n_st <= n_st + 1;
        st_prev <= st_last;
        st_last <= cyc;
      end else begin
        n_msg <= n_msg + 1;
        if (fifo_cnt == 8'd0) n_under <= n_under + 1;
      end
    end
    if (m_chipselect && m_write) begin
      n_wr <= n_wr + 1;
      wr_data <= m_writedata;
      wr_addr <= m_address;
    end
    if ((m_read && prev_read) || (m_chipselect != (m_read || m_write)) || (m_read && m_write))
      n_viol <= n_viol + 1;
    prev_read <= m_read;
    if (box_valid && box_ready) begin
      n_box <= n_box + 1;
      cap_l <= box_left;
      cap_t <= box_top;
      cap_r <= box_right;
      cap_b <= box_bottom;
      cap_p <= box_present;
      hs_st <= n_st;
      hs_msg <= n_msg;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_box(input string tag);
    int base;
    int k;
    base = n_box;
    k = 0;
    while (n_box == base && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(tag, n_box - base, 1);
  endtask

  task automatic wait_state(input string tag, input logic [3:0] st);
    int k;
    k = 0;
    while (dbg_state != st && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(tag, 32'(dbg_state), 32'(st));
  endtask

  task automatic chk_box(input string tag, input int l, input int t, input int r, input int b, input int p);
    chk({tag, "_left"}, 32'(cap_l), l);
    chk({tag, "_top"}, 32'(cap_t), t);
    chk({tag, "_right"}, 32'(cap_r), r);
    chk({tag, "_bottom"}, 32'(cap_b), b);
    chk({tag, "_present"}, 32'(cap_p), p);
  endtask

  int base_st, base_msg, base_wr, base_box, mm_busy, unstable, k;
  logic [10:0] s_l, s_t, s_r, s_b;

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    box_ready = 1'b1;
    tick(3);

    // Reset state
    chk("rst_cs", 32'(m_chipselect), 0);
    chk("rst_read", 32'(m_read), 0);
    chk("rst_write", 32'(m_write), 0);
    chk("rst_wdata", m_writedata, 0);
    chk("rst_valid", 32'(box_valid), 0);
    chk("rst_present", 32'(box_present), 0);
    chk("rst_left", 32'(box_left), 0);
    chk("rst_sync", 32'(sync_err_cnt), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // One clean message
    push(MSG_ID);
    push(32'h0064_0032);
    push(32'h00C8_0096);
    reset = 1'b0;
    wait_box("t1_box");
    chk_box("t1", 100, 50, 200, 150, 1);
    chk("t1_status_reads", hs_st, 1);
    chk("t1_msg_reads", hs_msg, 3);
    tick(2 * P);
    chk("t1_one_pulse", n_box, 1);

    // Count stuck at 2: status polls only, spaced P+2
    base_st = n_st;
    base_msg = n_msg;
    push(MSG_ID);
    push(32'h027F_01DF);
    tick(3 * P + 10);
    chk("t2_no_msg_reads", n_msg - base_msg, 0);
    chk("t2_polls_seen", 32'((n_st - base_st) >= 2), 1);
    chk("t2_poll_spacing", st_last - st_prev, P + 2);

    // Third word arrives: max coordinates, inverted box
    push(32'h0000_0000);
    wait_box("t3_box");
    chk_box("t3", 639, 479, 0, 0, 0);

    // Garbage word ahead of a message
    base_box = n_box;
    base_wr = n_wr;
    push(32'hDEAD_BEEF);
    push(MSG_ID);
    push(32'h0010_0020);
    push(32'h0030_0040);
`ifdef IMGPROC_MSGRD_FLUSH_EN
    tick(6 * P);
    chk("t4_sync", 32'(sync_err_cnt), 1);
    chk("t4_writes", n_wr - base_wr, 1);
    chk("t4_wr_data", wr_data, 32'h10);
    chk("t4_wr_addr", 32'(wr_addr), 0);
    chk("t4_no_box", n_box - base_box, 0);
    chk("t4_fifo_empty", 32'(fifo_cnt), 0);
`else
    wait_box("t4_box");
    chk("t4_sync", 32'(sync_err_cnt), 1);
    chk("t4_writes", n_wr - base_wr, 0);
    chk_box("t4", 16, 32, 48, 64, 1);
`endif

    // Back-pressure with two messages buffered
    box_ready = 1'b0;
    push(MSG_ID);
    push(32'h0005_0006);
    push(32'h0007_0008);
    push(MSG_ID);
    push(32'h000A_000B);
    push(32'h000C_000D);
    k = 0;
    while (!box_valid && k < 400) begin
      tick(1);
      k++;
    end
    chk("t5_valid", 32'(box_valid), 1);
    chk("t5a_left", 32'(box_left), 5);
    chk("t5a_top", 32'(box_top), 6);
    chk("t5a_right", 32'(box_right), 7);
    chk("t5a_bottom", 32'(box_bottom), 8);
    s_l = box_left; s_t = box_top; s_r = box_right; s_b = box_bottom;
    mm_busy = 0;
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (m_chipselect) mm_busy++;
      if (!box_valid || box_left != s_l || box_top != s_t || box_right != s_r || box_bottom != s_b)
        unstable++;
    end
    chk("t5_stable", unstable, 0);
    chk("t5_no_mm", mm_busy, 0);
    box_ready = 1'b1;
    tick(1);
    chk("t5_poll_after_hs", 32'(m_read && m_address == STATUS_ADDR), 1);
    chk("t5_poll_state", 32'(dbg_state), 32'(ST_POLL_RD));
    wait_box("t5b_box");
    chk_box("t5b", 10, 11, 12, 13, 1);

    // Reset while waiting on the top-left word
    push(MSG_ID);
    push(32'h0001_0002);
    push(32'h0003_0004);
    wait_state("t6_reach_tlwt", 4'(ST_TL_WT));
    reset = 1'b1;
    #1;
    chk("t6_read_low", 32'(m_read), 0);
    chk("t6_valid_low", 32'(box_valid), 0);
    chk("t6_state", 32'(dbg_state), 32'(ST_IDLE));
    tick(2);
    reset = 1'b0;
    chk("t6_state_rel", 32'(dbg_state), 32'(ST_IDLE));
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!m_read && k < 50);
    chk("t6_timer_reload", k, P);

    // Leftover bottom-right word gets resynced away
    base_box = n_box;
    base_wr = n_wr;
    push(MSG_ID);
    push(32'h0009_0009);
    push(32'h0009_0009);
`ifdef IMGPROC_MSGRD_FLUSH_EN
    tick(6 * P);
    chk("t6_sync", 32'(sync_err_cnt), 1);
    chk("t6_writes", n_wr - base_wr, 1);
    chk("t6_no_box", n_box - base_box, 0);
`else
    wait_box("t6_box");
    chk("t6_sync", 32'(sync_err_cnt), 1);
    chk_box("t6", 9, 9, 9, 9, 1);
`endif

    // enable dropped mid-message: message completes, then no further polls
    push(MSG_ID);
    push(32'h0001_0001);
    push(32'h0002_0002);
    wait_state("t7_reach_idwt", 4'(ST_ID_WT));
    enable = 1'b0;
    wait_box("t7_box");
    chk_box("t7", 1, 1, 2, 2, 1);
    tick(3 * P);
    chk("t7_no_polls", n_st - hs_st, 0);
    chk("t7_idle", 32'(dbg_state), 32'(ST_IDLE));

    chk("bus_protocol", n_viol, 0);
    chk("no_empty_pop", n_under, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
